// File: rtl/register_file_mp_pkg.sv
// Shared definitions for the multi-port register file: dump FSM encoding and default sizes.
package register_file_mp_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_ADDR_W  = 3;
  localparam int unsigned DEF_N_RD    = 2;
  localparam int unsigned DEF_BYPASS  = 1;
  localparam int unsigned DEF_ZERO_R0 = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/register_file_mp_dump_fsm.sv
// Dump sequencer: walks every register index once and streams it out over a valid/ready beat.
module rf_dump_fsm
  import register_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic              dump_ready,
  input  logic [DATA_W-1:0] lookup_data,
  output logic [ADDR_W-1:0] lookup_addr_c,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_dest,
  input  logic [DATA_W-1:0] wr_data,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  dump_state_t state;

  // Index whose value is loaded into dump_data at the next edge (beat 0 when starting).
  assign lookup_addr_c = (state == ST_SCAN) ? ADDR_W'(dump_addr + 1'b1) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dump_start) begin
            state      <= ST_SCAN;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
            dump_addr  <= '0;
            dump_data  <= lookup_data;
          end
        end
        ST_SCAN: begin
          if (dump_ready) begin
            if (dump_addr == LAST_ADDR) begin
              state      <= ST_DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_addr <= lookup_addr_c;
              dump_data <= lookup_data;
            end
          end else if (wr_en && (wr_dest == dump_addr)) begin
            // A stalled beat tracks writes to its register so the sink sees the newest value.
            dump_data <= wr_data;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          dump_done <= 1'b0;
          dump_busy <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          dump_valid <= 1'b0;
          dump_busy  <= 1'b0;
          dump_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Register file with N_RD combinational read ports, one write port, optional
// write-through forwarding, hardwired-zero R0 and a streaming dump interface.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned N_RD    = DEF_N_RD,
  parameter int unsigned BYPASS  = DEF_BYPASS,
  parameter int unsigned ZERO_R0 = DEF_ZERO_R0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_write_en,
  input  logic [ADDR_W-1:0]        reg_write_dest,
  input  logic [DATA_W-1:0]        reg_write_data,
  input  logic [N_RD*ADDR_W-1:0]   reg_read_addr,
  output logic [N_RD*DATA_W-1:0]   reg_read_data,
  input  logic                     dump_start,
  input  logic                     dump_ready,
  output logic                     dump_valid,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_busy,
  output logic                     dump_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              write_ok;
  logic [ADDR_W-1:0] lookup_addr_c;
  logic [DATA_W-1:0] lookup_data_c;

  // A write takes effect only out of reset and never on a hardwired-zero R0.
  assign write_ok = reg_write_en && rst &&
                    !((ZERO_R0 != 0) && (reg_write_dest == '0));

  function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] a);
    if ((ZERO_R0 != 0) && (a == '0)) return '0;
    if ((BYPASS != 0) && write_ok && (a == reg_write_dest)) return reg_write_data;
    return regs[a];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else if (write_ok) begin
      regs[reg_write_dest] <= reg_write_data;
    end
  end

  always_comb begin
    reg_read_data = '0;
    for (int k = 0; k < int'(N_RD); k++) begin
      reg_read_data[k*int'(DATA_W) +: DATA_W] =
        read_value(reg_read_addr[k*int'(ADDR_W) +: ADDR_W]);
    end
  end

  always_comb begin
    lookup_data_c = read_value(lookup_addr_c);
  end

  rf_dump_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dump_fsm (
    .clk           (clk),
    .rst           (rst),
    .dump_start    (dump_start),
    .dump_ready    (dump_ready),
    .lookup_data   (lookup_data_c),
    .lookup_addr_c (lookup_addr_c),
    .wr_en         (write_ok),
    .wr_dest       (reg_write_dest),
    .wr_data       (reg_write_data),
    .dump_valid    (dump_valid),
    .dump_addr     (dump_addr),
    .dump_data     (dump_data),
    .dump_busy     (dump_busy),
    .dump_done     (dump_done)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: default instance plus a BYPASS=0 twin on shared inputs.
module tb_register_file_mp;

  typedef struct {
    logic        we;
    logic [2:0]  dest;
    logic [15:0] wd;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [15:0] n0;
    logic [15:0] n1;
  } vec_t;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [5:0]  reg_read_addr;
  logic [31:0] rdata, nb_rdata;
  logic        dump_start, dump_ready;
  logic        dump_valid, dump_busy, dump_done;
  logic [2:0]  dump_addr;
  logic [15:0] dump_data;
  logic        nb_valid, nb_busy, nb_done;
  logic [2:0]  nb_addr;
  logic [15:0] nb_data;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mdl [8];
  beat_t       sbq [$];
  vec_t        vecs [7];

  always #5 clk = ~clk;

  register_file_mp dut (
    .clk(clk), .rst(rst), .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data), .reg_read_addr(reg_read_addr), .reg_read_data(rdata),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  register_file_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data), .reg_read_addr(reg_read_addr), .reg_read_data(nb_rdata),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(nb_valid),
    .dump_addr(nb_addr), .dump_data(nb_data), .dump_busy(nb_busy), .dump_done(nb_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One dump: expected beats queued at start, popped on each accepted beat.
  task automatic run_dump(input int stall_addr, input int abort_addr, input int exp_done);
    beat_t b;
    int    stall_cnt = 0;
    bit    done_seen = 1'b0;
    bit    aborted   = 1'b0;
    sbq.delete();
    if (stall_addr >= 0) mdl[stall_addr] = 16'hABCD;
    for (int i = 0; i < 8; i++) begin
      b.addr = 3'(i);
      b.data = (i == 0) ? 16'h0000 : mdl[i];
      sbq.push_back(b);
    end
    dump_ready = 1'b1;
    dump_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      dump_start   = (c == 3);
      reg_write_en = 1'b0;
      if (stall_addr >= 0 && dump_valid && dump_addr == 3'(stall_addr) && stall_cnt < 3) begin
        dump_ready = 1'b0;
        stall_cnt++;
        if (stall_cnt == 1) begin
          chk("stall_old_data", 32'(dump_data), 32'h0004);
          reg_write_en   = 1'b1;
          reg_write_dest = 3'(stall_addr);
          reg_write_data = 16'hABCD;
        end else begin
          chk("stall_addr_hold", 32'(dump_addr), 32'(stall_addr));
          chk("stall_data_refresh", 32'(dump_data), 32'hABCD);
        end
      end else begin
        dump_ready = 1'b1;
      end
      if (abort_addr >= 0 && dump_valid && dump_addr == 3'(abort_addr)) begin
        rst            = 1'b0;
        reg_write_en   = 1'b1;
        reg_write_dest = 3'd2;
        reg_write_data = 16'h5555;
        reg_read_addr  = {3'd2, 3'd5};
        #1;
        chk("abort_valid", 32'(dump_valid), 0);
        chk("abort_nb_valid", 32'(nb_valid), 0);
        chk("abort_busy", 32'(dump_busy), 0);
        chk("abort_addr", 32'(dump_addr), 0);
        chk("abort_data", 32'(dump_data), 0);
        chk("abort_r5", 32'(rdata[15:0]), 0);
        chk("abort_r2_in_reset", 32'(rdata[31:16]), 0);
        aborted = 1'b1;
        break;
      end
      #1;
      if (dump_valid && dump_ready) begin
        if (sbq.size() == 0) begin
          chk("extra_beat", 32'(dump_addr), 32'hFFFF);
        end else begin
          b = sbq.pop_front();
          chk("beat_addr", 32'(dump_addr), 32'(b.addr));
          chk("beat_data", 32'(dump_data), 32'(b.data));
          chk("beat_busy", 32'(dump_busy), 1);
          chk("nb_beat_addr", 32'(nb_addr), 32'(b.addr));
          chk("nb_beat_data", 32'(nb_data), 32'(b.data));
        end
      end
      if (dump_done) begin
        chk("done_cycle", 32'(c), 32'(exp_done));
        chk("done_busy", 32'(dump_busy), 1);
        chk("nb_done", 32'(nb_done), 1);
        done_seen = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      chk("done_seen", 32'(done_seen), 1);
      chk("beats_left", 32'(sbq.size()), 0);
      cyc();
      chk("done_pulse_end", 32'(dump_done), 0);
      chk("busy_end", 32'(dump_busy), 0);
      chk("nb_busy_end", 32'(nb_busy), 0);
      chk("valid_end", 32'(dump_valid), 0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd3, 16'h1234, 3'd3, 3'd3, 16'h1234, 16'h1234, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 16'h1234, 16'h0000, 16'h1234, 16'h0000};
    vecs[2] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, 16'h0000, 16'h1234, 16'h0000, 16'h1234};
    vecs[4] = '{1'b1, 3'd7, 16'hBEEF, 3'd7, 3'd6, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{1'b1, 3'd7, 16'hCAFE, 3'd7, 3'd3, 16'hCAFE, 16'h1234, 16'hBEEF, 16'h1234};
    vecs[6] = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd7, 16'hCAFE, 16'hCAFE, 16'hCAFE, 16'hCAFE};
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;

    rst = 1'b0; reg_write_en = 1'b0; reg_write_dest = '0; reg_write_data = '0;
    reg_read_addr = '0; dump_start = 1'b0; dump_ready = 1'b0;
    repeat (2) cyc();
    chk("rst_valid", 32'(dump_valid), 0);
    chk("rst_addr", 32'(dump_addr), 0);
    chk("rst_data", 32'(dump_data), 0);
    chk("rst_busy", 32'(dump_busy), 0);
    chk("rst_done", 32'(dump_done), 0);
    rst = 1'b1;

    // Every address reads back zero after reset on both ports.
    for (int a = 0; a < 8; a++) begin
      cyc();
      reg_read_addr = {3'(7 - a), 3'(a)};
      #1;
      chk("init_p0", 32'(rdata[15:0]), 0);
      chk("init_p1", 32'(rdata[31:16]), 0);
    end

    for (int i = 0; i < 7; i++) begin
      cyc();
      reg_write_en   = vecs[i].we;
      reg_write_dest = vecs[i].dest;
      reg_write_data = vecs[i].wd;
      reg_read_addr  = {vecs[i].ra1, vecs[i].ra0};
      #1;
      chk($sformatf("vec%0d_p0", i), 32'(rdata[15:0]), 32'(vecs[i].e0));
      chk($sformatf("vec%0d_p1", i), 32'(rdata[31:16]), 32'(vecs[i].e1));
      chk($sformatf("vec%0d_nb_p0", i), 32'(nb_rdata[15:0]), 32'(vecs[i].n0));
      chk($sformatf("vec%0d_nb_p1", i), 32'(nb_rdata[31:16]), 32'(vecs[i].n1));
    end
    cyc();
    reg_write_en = 1'b0;

    for (int r = 1; r < 8; r++) begin
      cyc();
      reg_write_en   = 1'b1;
      reg_write_dest = 3'(r);
      reg_write_data = 16'(r);
      mdl[r]         = 16'(r);
    end
    cyc();
    reg_write_en = 1'b0;

    run_dump(-1, -1, 9);
    run_dump(4, -1, 12);
    run_dump(-1, 5, 0);

    // Held in reset for a few cycles: no done pulse may appear, writes are dropped.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset_no_done", 32'(dump_done), 0);
    end
    rst = 1'b1;
    reg_write_en = 1'b0;
    cyc();
    chk("post_reset_r5", 32'(rdata[15:0]), 0);
    chk("post_reset_r2", 32'(rdata[31:16]), 0);
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    run_dump(-1, -1, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
